// File: rtl/mycpu_pipe_ctrl_if.sv
// Pipeline control bundle between the decode stage and the sequencer.
// master: decode/IF/MEM side drives fields; slave: sequencer drives enables.
interface mycpu_pipe_ctrl_if #(
    parameter int AW = 5
);
    logic          if_valid;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic          id_rs_used;
    logic          id_rt_used;
    logic          id_wen;
    logic [AW-1:0] id_waddr;
    logic          mem_busy;

    logic          id_allowin;
    logic          id_en;
    logic          ex_en;
    logic          mem_en;
    logic          id_valid;
    logic          ex_valid;
    logic          mem_valid;
    logic          wb_valid;
    logic          id_stall;
    logic          wb_wen;
    logic [AW-1:0] wb_waddr;

    modport master (
        output if_valid, id_rs, id_rt, id_rs_used, id_rt_used,
        output id_wen, id_waddr, mem_busy,
        input  id_allowin, id_en, ex_en, mem_en,
        input  id_valid, ex_valid, mem_valid, wb_valid,
        input  id_stall, wb_wen, wb_waddr
    );

    modport slave (
        input  if_valid, id_rs, id_rt, id_rs_used, id_rt_used,
        input  id_wen, id_waddr, mem_busy,
        output id_allowin, id_en, ex_en, mem_en,
        output id_valid, ex_valid, mem_valid, wb_valid,
        output id_stall, wb_wen, wb_waddr
    );
endinterface

// File: rtl/mycpu_pipe_ctrl.sv
// Pipeline sequencer + RAW scoreboard for the 5-stage core (no forwarding).
// Ports: clk, rst (sync, active-high), ctl (slave: decode fields in, enables/valids out).
module mycpu_pipe_ctrl #(
    parameter int NREG  = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    mycpu_pipe_ctrl_if.slave ctl
);
    logic                      id_valid_q, id_valid_d;
    logic                      ex_valid_q, ex_valid_d;
    logic                      mem_valid_q, mem_valid_d;
    logic                      wb_valid_q, wb_valid_d;
    logic                      ex_wen_q, ex_wen_d;
    logic                      mem_wen_q, mem_wen_d;
    logic                      wb_wen_q, wb_wen_d;
    logic [AW-1:0]             ex_waddr_q, ex_waddr_d;
    logic [AW-1:0]             mem_waddr_q, mem_waddr_d;
    logic [AW-1:0]             wb_waddr_q, wb_waddr_d;
    logic [NREG-1:0][CNT_W-1:0] cnt_q, cnt_d;

    logic hazard;
    logic aw_id, aw_ex, aw_mem;
    logic rs_busy, rt_busy;
    logic inc_en, dec_en;
    logic id_wtrk;

    // The regfile read is not write-through, so a count held by WB still blocks.
    assign rs_busy = ctl.id_rs_used && (ctl.id_rs != '0)
                     && (cnt_q[ctl.id_rs] != '0);
    assign rt_busy = ctl.id_rt_used && (ctl.id_rt != '0)
                     && (cnt_q[ctl.id_rt] != '0);
    assign hazard  = id_valid_q && (rs_busy || rt_busy);

    // WB always retires, so MEM is the only stage that can back-pressure.
    assign aw_mem = !mem_valid_q || !ctl.mem_busy;
    assign aw_ex  = !ex_valid_q || aw_mem;
    assign aw_id  = !id_valid_q || (!hazard && aw_ex);

    // Writes to $0 are dropped here so they are never tracked or retired.
    assign id_wtrk = ctl.id_wen && (ctl.id_waddr != '0);
    assign inc_en  = id_valid_q && !hazard && aw_ex && id_wtrk;
    assign dec_en  = wb_valid_q && wb_wen_q;

    always_comb begin
        id_valid_d  = id_valid_q;
        ex_valid_d  = ex_valid_q;
        ex_wen_d    = ex_wen_q;
        ex_waddr_d  = ex_waddr_q;
        mem_valid_d = mem_valid_q;
        mem_wen_d   = mem_wen_q;
        mem_waddr_d = mem_waddr_q;
        if (aw_id) begin
            id_valid_d = ctl.if_valid;
        end
        if (aw_ex) begin
            ex_valid_d = id_valid_q && !hazard;
            ex_wen_d   = id_wtrk;
            ex_waddr_d = ctl.id_waddr;
        end
        if (aw_mem) begin
            mem_valid_d = ex_valid_q;
            mem_wen_d   = ex_wen_q;
            mem_waddr_d = ex_waddr_q;
        end
        wb_valid_d = mem_valid_q && !ctl.mem_busy;
        wb_wen_d   = mem_wen_q;
        wb_waddr_d = mem_waddr_q;
    end

    always_comb begin
        cnt_d = cnt_q;
        for (int r = 1; r < NREG; r++) begin
            logic up, dn;
            up = inc_en && (ctl.id_waddr == AW'(r));
            dn = dec_en && (wb_waddr_q == AW'(r));
            if (up && !dn) begin
                cnt_d[r] = cnt_q[r] + CNT_W'(1);
            end else if (dn && !up) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
        end
        cnt_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid_q  <= 1'b0;
            ex_valid_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            wb_valid_q  <= 1'b0;
            ex_wen_q    <= 1'b0;
            mem_wen_q   <= 1'b0;
            wb_wen_q    <= 1'b0;
            ex_waddr_q  <= '0;
            mem_waddr_q <= '0;
            wb_waddr_q  <= '0;
            cnt_q       <= '0;
        end else begin
            id_valid_q  <= id_valid_d;
            ex_valid_q  <= ex_valid_d;
            mem_valid_q <= mem_valid_d;
            wb_valid_q  <= wb_valid_d;
            ex_wen_q    <= ex_wen_d;
            mem_wen_q   <= mem_wen_d;
            wb_wen_q    <= wb_wen_d;
            ex_waddr_q  <= ex_waddr_d;
            mem_waddr_q <= mem_waddr_d;
            wb_waddr_q  <= wb_waddr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign ctl.id_allowin = rst || aw_id;
    assign ctl.id_en      = aw_ex;
    assign ctl.ex_en      = aw_mem;
    assign ctl.mem_en     = 1'b1;
    assign ctl.id_valid   = id_valid_q;
    assign ctl.ex_valid   = ex_valid_q;
    assign ctl.mem_valid  = mem_valid_q;
    assign ctl.wb_valid   = wb_valid_q;
    assign ctl.id_stall   = hazard;
    assign ctl.wb_wen     = wb_valid_q && wb_wen_q;
    assign ctl.wb_waddr   = wb_waddr_q;
endmodule

// File: tb/tb_mycpu_pipe_ctrl.sv
// Directed bench for mycpu_pipe_ctrl.
// Drives decode fields per cycle and checks enables, valids and scoreboard.
module tb_mycpu_pipe_ctrl;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    mycpu_pipe_ctrl_if #(.AW(5)) bus ();

    mycpu_pipe_ctrl #(
        .NREG (32),
        .AW   (5),
        .CNT_W(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ctl(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int cnt_sum();
        int s;
        s = 0;
        for (int i = 0; i < 32; i++) s += int'(dut.cnt_q[i]);
        return s;
    endfunction

    function automatic int cnt_of(input int r);
        return int'(dut.cnt_q[r]);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [4:0] rs, input logic ru,
                       input logic [4:0] rt, input logic tu,
                       input logic we, input logic [4:0] wa, input logic mb);
        bus.if_valid   = v;
        bus.id_rs      = rs;
        bus.id_rs_used = ru;
        bus.id_rt      = rt;
        bus.id_rt_used = tu;
        bus.id_wen     = we;
        bus.id_waddr   = wa;
        bus.mem_busy   = mb;
        #1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            put(0, 0, 0, 0, 0, 0, 0, 0);
        end
    endtask

    // Counter range guard: no dec from 0, no inc at 3.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.wb_wen)
                check("cnt_nz_dec",
                      32'(dut.cnt_q[bus.wb_waddr] != 2'd0), 32'd1);
            if (bus.id_valid && !bus.id_stall && bus.id_en
                && bus.id_wen && bus.id_waddr != 5'd0)
                check("cnt_n3_inc",
                      32'(dut.cnt_q[bus.id_waddr] != 2'd3), 32'd1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        put(0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        put(0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_idv", 32'(bus.id_valid), 0);
        check("rst_exv", 32'(bus.ex_valid), 0);
        check("rst_memv", 32'(bus.mem_valid), 0);
        check("rst_wbv", 32'(bus.wb_valid), 0);
        check("rst_wbwen", 32'(bus.wb_wen), 0);
        check("rst_wbaddr", 32'(bus.wb_waddr), 0);
        check("rst_allow", 32'(bus.id_allowin), 1);
        check("rst_cnt", 32'(cnt_sum()), 0);

        // 1: independent stream, Ik in ID at cycle k writes $k
        rst = 1'b0;
        put(1, 20, 1, 21, 1, 0, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            cyc();
            put(k < 8, 20, 1, 21, 1, 1, 5'(k), 0);
            check("s1_stall", 32'(bus.id_stall), 0);
            check("s1_idv", 32'(bus.id_valid), 1);
            check("s1_exv", 32'(bus.ex_valid), 32'(k >= 2));
            check("s1_memv", 32'(bus.mem_valid), 32'(k >= 3));
            check("s1_wbv", 32'(bus.wb_valid), 32'(k >= 4));
            check("s1_wbwen", 32'(bus.wb_wen), 32'(k >= 4));
            if (k >= 4) check("s1_wbaddr", 32'(bus.wb_waddr), 32'(k - 3));
        end
        drain(4);
        check("s1_cnt0", 32'(cnt_sum()), 0);
        check("s1_wbv_end", 32'(bus.wb_valid), 0);

        // 2: A writes $5, B reads $5
        cyc(); put(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(); put(1, 0, 0, 0, 0, 1, 5, 0);
        check("s2_c1_stall", 32'(bus.id_stall), 0);
        cyc(); put(0, 5, 1, 0, 0, 0, 0, 0);
        check("s2_c2_stall", 32'(bus.id_stall), 1);
        check("s2_c2_allow", 32'(bus.id_allowin), 0);
        check("s2_c2_exv", 32'(bus.ex_valid), 1);
        check("s2_c2_cnt5", 32'(cnt_of(5)), 1);
        cyc(); put(0, 5, 1, 0, 0, 0, 0, 0);
        check("s2_c3_stall", 32'(bus.id_stall), 1);
        check("s2_c3_exv", 32'(bus.ex_valid), 0);
        cyc(); put(0, 5, 1, 0, 0, 0, 0, 0);
        check("s2_c4_stall", 32'(bus.id_stall), 1);
        check("s2_c4_wbwen", 32'(bus.wb_wen), 1);
        check("s2_c4_wbaddr", 32'(bus.wb_waddr), 5);
        cyc(); put(0, 5, 1, 0, 0, 0, 0, 0);
        check("s2_c5_stall", 32'(bus.id_stall), 0);
        check("s2_c5_exv", 32'(bus.ex_valid), 0);
        check("s2_c5_cnt5", 32'(cnt_of(5)), 0);
        check("s2_c5_iden", 32'(bus.id_en), 1);
        cyc(); put(0, 0, 0, 0, 0, 0, 0, 0);
        check("s2_c6_exv", 32'(bus.ex_valid), 1);
        check("s2_c6_idv", 32'(bus.id_valid), 0);
        drain(4);

        // 3: A writes $0, B reads $0
        cyc(); put(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(); put(1, 0, 0, 0, 0, 1, 0, 0);
        cyc(); put(0, 0, 1, 0, 1, 0, 0, 0);
        check("s3_c2_stall", 32'(bus.id_stall), 0);
        check("s3_c2_cnt", 32'(cnt_sum()), 0);
        cyc(); put(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(); put(0, 0, 0, 0, 0, 0, 0, 0);
        check("s3_c4_wbv", 32'(bus.wb_valid), 1);
        check("s3_c4_wbwen", 32'(bus.wb_wen), 0);
        check("s3_c4_cnt", 32'(cnt_sum()), 0);
        drain(4);

        // 4: mem_busy cycles 4..7 with EX and MEM full
        cyc(); put(1, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 1; c <= 3; c++) begin
            cyc(); put(1, 0, 0, 0, 0, 1, 5'(9 + c), 0);
        end
        cyc(); put(1, 0, 0, 0, 0, 1, 13, 1);
        check("s4_c4_allow", 32'(bus.id_allowin), 0);
        check("s4_c4_wbv", 32'(bus.wb_valid), 1);
        check("s4_c4_wbaddr", 32'(bus.wb_waddr), 10);
        for (int c = 5; c <= 7; c++) begin
            cyc(); put(1, 0, 0, 0, 0, 1, 13, 1);
            check("s4_hold_exv", 32'(bus.ex_valid), 1);
            check("s4_hold_memv", 32'(bus.mem_valid), 1);
            check("s4_hold_wbv", 32'(bus.wb_valid), 0);
            check("s4_hold_allow", 32'(bus.id_allowin), 0);
        end
        check("s4_cnt10", 32'(cnt_of(10)), 0);
        cyc(); put(1, 0, 0, 0, 0, 1, 13, 0);
        check("s4_c8_allow", 32'(bus.id_allowin), 1);
        cyc(); put(0, 0, 0, 0, 0, 1, 14, 0);
        check("s4_c9_wbaddr", 32'(bus.wb_waddr), 11);
        check("s4_c9_wbwen", 32'(bus.wb_wen), 1);
        for (int c = 10; c <= 12; c++) begin
            cyc(); put(0, 0, 0, 0, 0, 0, 0, 0);
            check("s4_seq_wbwen", 32'(bus.wb_wen), 1);
            check("s4_seq_wbaddr", 32'(bus.wb_waddr), 32'(c + 2));
        end
        cyc(); put(0, 0, 0, 0, 0, 0, 0, 0);
        check("s4_c13_wbv", 32'(bus.wb_valid), 0);
        check("s4_cnt_end", 32'(cnt_sum()), 0);

        // 5: writers to $7 at c1, c2, c4 (filler $9 at c3)
        begin
            logic [4:0] wa [1:4];
            int         exp7 [1:8];
            wa[1] = 7; wa[2] = 7; wa[3] = 9; wa[4] = 7;
            exp7 = '{0, 1, 2, 2, 2, 1, 1, 0};
            cyc(); put(1, 0, 0, 0, 0, 0, 0, 0);
            for (int c = 1; c <= 8; c++) begin
                cyc();
                if (c <= 4) put(c < 4, 0, 0, 0, 0, 1, wa[c], 0);
                else put(0, 0, 0, 0, 0, 0, 0, 0);
                check("s5_cnt7", 32'(cnt_of(7)), 32'(exp7[c]));
            end
            drain(1);
        end

        // 6: reset with all stages valid and cnt[3]=2
        cyc(); put(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(); put(1, 0, 0, 0, 0, 1, 3, 0);
        cyc(); put(1, 0, 0, 0, 0, 1, 3, 0);
        cyc(); put(1, 0, 0, 0, 0, 1, 4, 0);
        cyc();
        rst = 1'b1;
        put(0, 0, 0, 0, 0, 1, 5, 0);
        check("s6_allv", 32'({bus.id_valid, bus.ex_valid,
                              bus.mem_valid, bus.wb_valid}), 32'hf);
        check("s6_cnt3", 32'(cnt_of(3)), 2);
        check("s6_rst_allow", 32'(bus.id_allowin), 1);
        cyc();
        rst = 1'b0;
        put(1, 0, 0, 0, 0, 0, 0, 0);
        check("s6_valids", 32'({bus.id_valid, bus.ex_valid,
                                bus.mem_valid, bus.wb_valid}), 0);
        check("s6_cnt", 32'(cnt_sum()), 0);
        check("s6_allow", 32'(bus.id_allowin), 1);
        check("s6_wbwen", 32'(bus.wb_wen), 0);
        cyc(); put(0, 3, 1, 3, 1, 0, 0, 0);
        check("s6_rd3_idv", 32'(bus.id_valid), 1);
        check("s6_rd3_stall", 32'(bus.id_stall), 0);
        drain(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
